// File: rtl/recorder_mode_ctrl_if.sv
// Key/status inputs and mode/speed/datapath-control outputs of the recorder mode controller.
// The controller connects through the slave modport; whatever drives the keys uses master.
interface recorder_mode_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              i_key_record;
  logic              i_key_play;
  logic              i_key_stop;
  logic              i_key_up;
  logic              i_key_down;
  logic              i_init_done;
  logic              i_rec_full;
  logic              i_play_end;
  logic [ADDR_W-1:0] i_rec_addr;
  logic [2:0]        o_state;
  logic [4:0]        o_speed;
  logic              o_rec_start;
  logic              o_play_start;
  logic              o_rec_en;
  logic              o_play_en;
  logic [ADDR_W-1:0] o_rec_len;

  modport master (
    output i_key_record, i_key_play, i_key_stop, i_key_up, i_key_down,
    output i_init_done, i_rec_full, i_play_end, i_rec_addr,
    input  o_state, o_speed, o_rec_start, o_play_start, o_rec_en, o_play_en, o_rec_len
  );

  modport slave (
    input  i_key_record, i_key_play, i_key_stop, i_key_up, i_key_down,
    input  i_init_done, i_rec_full, i_play_end, i_rec_addr,
    output o_state, o_speed, o_rec_start, o_play_start, o_rec_en, o_play_en, o_rec_len
  );
endinterface

// File: rtl/recorder_mode_ctrl.sv
// Audio recorder mode controller: key pulses and datapath status in, registered
// mode code, signed playback speed, datapath start pulses/enables and record length out.
module recorder_mode_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int SPD_MAX = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  recorder_mode_ctrl_if.slave bus
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_RECORD = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_PLAY   = 3'd4;
  localparam logic [2:0] ST_PAUSE  = 3'd5;

  localparam logic [3:0] MAG_MAX    = 4'(SPD_MAX);
  localparam logic [4:0] SPD_NORMAL = 5'b0_0001;

  logic [2:0]        state_r;
  logic [2:0]        state_next_s;
  logic [4:0]        speed_r;
  logic [4:0]        speed_next_s;
  logic [ADDR_W-1:0] rec_len_r;
  logic [ADDR_W-1:0] rec_len_next_s;
  logic              rec_start_r;
  logic              play_start_r;
  logic              rec_en_r;
  logic              play_en_r;
  logic              speed_ok_s;

  // Speed is {slower, magnitude}. Stepping away from normal grows the magnitude up to
  // MAG_MAX; stepping back toward normal shrinks it, and magnitude 2 collapses to normal.
  function automatic logic [4:0] speed_step(input logic [4:0] spd, input logic faster);
    logic [4:0] res;
    if (spd == SPD_NORMAL) begin
      res = faster ? 5'b0_0010 : 5'b1_0010;
    end else if (spd[4] == !faster) begin
      res = (spd[3:0] >= MAG_MAX) ? {spd[4], MAG_MAX} : {spd[4], spd[3:0] + 4'd1};
    end else begin
      res = (spd[3:0] <= 4'd2) ? SPD_NORMAL : {spd[4], spd[3:0] - 4'd1};
    end
    return res;
  endfunction

  // Mode transitions and record-length capture; stop outranks record, record outranks play.
  always_comb begin
    state_next_s   = state_r;
    rec_len_next_s = rec_len_r;
    case (state_r)
      ST_INIT: begin
        if (bus.i_init_done) state_next_s = ST_IDLE;
        else                 state_next_s = ST_INIT;
      end
      ST_IDLE: begin
        if (bus.i_key_record) state_next_s = ST_RECORD;
        else                  state_next_s = ST_IDLE;
      end
      ST_RECORD: begin
        // An empty take is discarded so the previous recording stays playable.
        if (bus.i_key_stop || bus.i_rec_full) begin
          if (bus.i_rec_addr != {ADDR_W{1'b0}}) begin
            state_next_s   = ST_STOP;
            rec_len_next_s = bus.i_rec_addr;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_RECORD;
        end
      end
      ST_STOP: begin
        if (bus.i_key_stop)        state_next_s = ST_STOP;
        else if (bus.i_key_record) state_next_s = ST_RECORD;
        else if (bus.i_key_play)   state_next_s = ST_PLAY;
        else                       state_next_s = ST_STOP;
      end
      ST_PLAY: begin
        if (bus.i_key_stop || bus.i_play_end) state_next_s = ST_STOP;
        else if (bus.i_key_play)              state_next_s = ST_PAUSE;
        else                                  state_next_s = ST_PLAY;
      end
      ST_PAUSE: begin
        if (bus.i_key_stop)      state_next_s = ST_STOP;
        else if (bus.i_key_play) state_next_s = ST_PLAY;
        else                     state_next_s = ST_PAUSE;
      end
      default: state_next_s = ST_INIT;
    endcase
  end

  // Speed keys act only in modes where the user may adjust speed; up+down cancel out.
  always_comb begin
    speed_ok_s = (state_r == ST_IDLE) || (state_r == ST_STOP) ||
                 (state_r == ST_PLAY) || (state_r == ST_PAUSE);
    if (speed_ok_s && (bus.i_key_up ^ bus.i_key_down)) speed_next_s = speed_step(speed_r, bus.i_key_up);
    else                                               speed_next_s = speed_r;
  end

  // State, speed, length and the registered pulses/enables derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_INIT;
      speed_r      <= SPD_NORMAL;
      rec_len_r    <= {ADDR_W{1'b0}};
      rec_start_r  <= 1'b0;
      play_start_r <= 1'b0;
      rec_en_r     <= 1'b0;
      play_en_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      speed_r      <= speed_next_s;
      rec_len_r    <= rec_len_next_s;
      rec_start_r  <= (state_next_s == ST_RECORD) && (state_r != ST_RECORD);
      play_start_r <= (state_next_s == ST_PLAY) && (state_r == ST_STOP);
      rec_en_r     <= (state_next_s == ST_RECORD);
      play_en_r    <= (state_next_s == ST_PLAY);
    end
  end

  assign bus.o_state      = state_r;
  assign bus.o_speed      = speed_r;
  assign bus.o_rec_len    = rec_len_r;
  assign bus.o_rec_start  = rec_start_r;
  assign bus.o_play_start = play_start_r;
  assign bus.o_rec_en     = rec_en_r;
  assign bus.o_play_en    = play_en_r;

endmodule

// File: tb/tb_recorder_mode_ctrl.sv
// Bench for recorder_mode_ctrl: directed walk through the modes and speed range, then
// random keys/status compared each cycle against a mode-level reference model.
module tb_recorder_mode_ctrl;
  localparam int ADDR_W  = 20;
  localparam int SPD_MAX = 8;

  localparam logic [4:0] K_NONE = 5'b00000;
  localparam logic [4:0] K_STOP = 5'b10000;
  localparam logic [4:0] K_REC  = 5'b01000;
  localparam logic [4:0] K_PLAY = 5'b00100;
  localparam logic [4:0] K_UP   = 5'b00010;
  localparam logic [4:0] K_DN   = 5'b00001;

  localparam int M_INIT = 0, M_IDLE = 1, M_RECORD = 2, M_STOP = 3, M_PLAY = 4, M_PAUSE = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  recorder_mode_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  recorder_mode_ctrl #(.ADDR_W(ADDR_W), .SPD_MAX(SPD_MAX)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: mode number, speed as a signed integer (+1 normal, +m fast, -m slow).
  int                m_mode = M_INIT;
  int                m_speed = 1;
  logic [ADDR_W-1:0] m_len = '0;
  logic              m_rec_start = 1'b0;
  logic              m_play_start = 1'b0;

  function automatic logic [4:0] enc_speed(input int s);
    if (s < 0) return {1'b1, 4'(-s)};
    else       return {1'b0, 4'(s)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_tick(input logic r, input logic [4:0] k, input logic init,
                            input logic full, input logic pend, input logic [ADDR_W-1:0] addr);
    int nm;
    m_rec_start  = 1'b0;
    m_play_start = 1'b0;
    if (r) begin
      m_mode  = M_INIT;
      m_speed = 1;
      m_len   = '0;
      return;
    end
    if ((m_mode == M_IDLE || m_mode == M_STOP || m_mode == M_PLAY || m_mode == M_PAUSE)
        && (k[1] != k[0])) begin
      if (k[1]) begin
        if (m_speed == 1)       m_speed = 2;
        else if (m_speed >= 2)  m_speed = (m_speed < SPD_MAX) ? m_speed + 1 : SPD_MAX;
        else if (m_speed == -2) m_speed = 1;
        else                    m_speed = m_speed + 1;
      end else begin
        if (m_speed == 1)       m_speed = -2;
        else if (m_speed <= -2) m_speed = (m_speed > -SPD_MAX) ? m_speed - 1 : -SPD_MAX;
        else if (m_speed == 2)  m_speed = 1;
        else                    m_speed = m_speed - 1;
      end
    end
    nm = m_mode;
    case (m_mode)
      M_INIT:   if (init) nm = M_IDLE;
      M_IDLE:   if (k[3]) nm = M_RECORD;
      M_RECORD: if (k[4] || full) begin
                  if (addr != 0) begin nm = M_STOP; m_len = addr; end
                  else nm = M_IDLE;
                end
      M_STOP:   if (!k[4]) begin
                  if (k[3]) nm = M_RECORD;
                  else if (k[2]) nm = M_PLAY;
                end
      M_PLAY:   if (k[4] || pend) nm = M_STOP;
                else if (k[2]) nm = M_PAUSE;
      M_PAUSE:  if (k[4]) nm = M_STOP;
                else if (k[2]) nm = M_PLAY;
      default:  nm = M_INIT;
    endcase
    m_rec_start  = (nm == M_RECORD) && (m_mode != M_RECORD);
    m_play_start = (nm == M_PLAY) && (m_mode == M_STOP);
    m_mode = nm;
  endtask

  // Drive one cycle of inputs at the falling edge, clock once, compare at the next falling edge.
  task automatic step(input logic r, input logic [4:0] k, input logic init, input logic full,
                      input logic pend, input logic [ADDR_W-1:0] addr);
    rst              = r;
    bus.i_key_stop   = k[4];
    bus.i_key_record = k[3];
    bus.i_key_play   = k[2];
    bus.i_key_up     = k[1];
    bus.i_key_down   = k[0];
    bus.i_init_done  = init;
    bus.i_rec_full   = full;
    bus.i_play_end   = pend;
    bus.i_rec_addr   = addr;
    model_tick(r, k, init, full, pend, addr);
    @(negedge clk);
    check_eq("state",      32'(bus.o_state),      32'(m_mode));
    check_eq("speed",      32'(bus.o_speed),      32'(enc_speed(m_speed)));
    check_eq("rec_len",    32'(bus.o_rec_len),    32'(m_len));
    check_eq("rec_en",     32'(bus.o_rec_en),     32'(m_mode == M_RECORD));
    check_eq("play_en",    32'(bus.o_play_en),    32'(m_mode == M_PLAY));
    check_eq("rec_start",  32'(bus.o_rec_start),  32'(m_rec_start));
    check_eq("play_start", 32'(bus.o_play_start), 32'(m_play_start));
  endtask

  initial begin
    logic [4:0] k;
    logic [4:0] exp_spd;
    bus.i_key_stop = 1'b0; bus.i_key_record = 1'b0; bus.i_key_play = 1'b0;
    bus.i_key_up = 1'b0; bus.i_key_down = 1'b0; bus.i_init_done = 1'b0;
    bus.i_rec_full = 1'b0; bus.i_play_end = 1'b0; bus.i_rec_addr = '0;
    @(negedge clk);

    // Reset, then init handshake.
    repeat (3) step(1'b1, K_NONE, 1'b0, 1'b0, 1'b0, '0);
    check_eq("rst_state", 32'(bus.o_state), 32'd0);
    check_eq("rst_speed", 32'(bus.o_speed), 32'h01);
    check_eq("rst_len",   32'(bus.o_rec_len), 32'd0);
    step(1'b0, K_REC, 1'b0, 1'b0, 1'b0, '0);
    check_eq("init_hold", 32'(bus.o_state), 32'd0);
    step(1'b0, K_NONE, 1'b1, 1'b0, 1'b0, '0);
    check_eq("init_done", 32'(bus.o_state), 32'd1);
    step(1'b0, K_PLAY | K_STOP, 1'b1, 1'b0, 1'b0, '0);
    check_eq("idle_ign", 32'(bus.o_state), 32'd1);

    // Record, stop at 0x00400.
    step(1'b0, K_REC, 1'b1, 1'b0, 1'b0, '0);
    check_eq("rec_enter", 32'({bus.o_state, bus.o_rec_start, bus.o_rec_en}), 32'({3'd2, 1'b1, 1'b1}));
    step(1'b0, K_NONE, 1'b1, 1'b0, 1'b0, 20'h00400);
    check_eq("rec_hold", 32'({bus.o_rec_start, bus.o_rec_en}), 32'({1'b0, 1'b1}));
    step(1'b0, K_STOP, 1'b1, 1'b0, 1'b0, 20'h00400);
    check_eq("rec_stop", 32'({bus.o_state, bus.o_rec_len}), 32'({3'd3, 20'h00400}));

    // Full SRAM ends recording; an empty take returns to IDLE keeping the old length.
    step(1'b0, K_REC, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, K_NONE, 1'b1, 1'b1, 1'b0, 20'hFFFFF);
    check_eq("rec_full", 32'({bus.o_state, bus.o_rec_len}), 32'({3'd3, 20'hFFFFF}));
    step(1'b0, K_REC, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, K_STOP, 1'b1, 1'b0, 1'b0, '0);
    check_eq("rec_empty", 32'({bus.o_state, bus.o_rec_len}), 32'({3'd1, 20'hFFFFF}));
    step(1'b0, K_REC, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, K_STOP, 1'b1, 1'b0, 1'b0, 20'h00400);

    // Play / pause / resume / end.
    step(1'b0, K_PLAY, 1'b1, 1'b0, 1'b0, '0);
    check_eq("play_go", 32'({bus.o_state, bus.o_play_start, bus.o_play_en}), 32'({3'd4, 1'b1, 1'b1}));
    step(1'b0, K_NONE, 1'b1, 1'b0, 1'b0, '0);
    check_eq("play_pulse", 32'(bus.o_play_start), 32'd0);
    step(1'b0, K_PLAY, 1'b1, 1'b0, 1'b0, '0);
    check_eq("pause", 32'({bus.o_state, bus.o_play_en}), 32'({3'd5, 1'b0}));
    step(1'b0, K_PLAY | K_REC, 1'b1, 1'b0, 1'b0, '0);
    check_eq("resume", 32'({bus.o_state, bus.o_play_start}), 32'({3'd4, 1'b0}));
    step(1'b0, K_PLAY, 1'b1, 1'b0, 1'b1, '0);
    check_eq("play_end", 32'(bus.o_state), 32'd3);

    // Speed range walk from STOP.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, K_UP, 1'b1, 1'b0, 1'b0, '0);
      exp_spd = (i + 2 > SPD_MAX) ? 5'(SPD_MAX) : 5'(i + 2);
      check_eq("spd_up", 32'(bus.o_speed), 32'(exp_spd));
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, K_DN, 1'b1, 1'b0, 1'b0, '0);
      if (i < 6)       exp_spd = 5'(7 - i);
      else if (i == 6) exp_spd = 5'h01;
      else             exp_spd = (i - 7 + 2 > SPD_MAX) ? 5'(16 + SPD_MAX) : 5'(16 + i - 7 + 2);
      check_eq("spd_dn", 32'(bus.o_speed), 32'(exp_spd));
    end
    step(1'b0, K_UP | K_DN, 1'b1, 1'b0, 1'b0, '0);
    check_eq("spd_both", 32'(bus.o_speed), 32'h18);
    step(1'b0, K_REC, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, K_UP, 1'b1, 1'b0, 1'b0, '0);
    check_eq("spd_rec", 32'(bus.o_speed), 32'h18);
    step(1'b0, K_STOP, 1'b1, 1'b0, 1'b0, 20'h00010);

    // Key priority and reset during play.
    step(1'b0, K_PLAY, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, K_STOP | K_REC | K_PLAY, 1'b1, 1'b0, 1'b0, '0);
    check_eq("prio_play", 32'(bus.o_state), 32'd3);
    step(1'b0, K_REC | K_PLAY, 1'b1, 1'b0, 1'b0, '0);
    check_eq("prio_stop", 32'(bus.o_state), 32'd2);
    step(1'b0, K_STOP, 1'b1, 1'b0, 1'b0, 20'h00020);
    repeat (3) step(1'b0, K_UP, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, K_PLAY, 1'b1, 1'b0, 1'b0, '0);
    check_eq("pre_rst", 32'({bus.o_state, bus.o_speed}), 32'({3'd4, 5'h15}));
    step(1'b1, K_PLAY | K_UP, 1'b1, 1'b0, 1'b0, '0);
    check_eq("mid_rst", 32'({bus.o_state, bus.o_speed, bus.o_play_en}), 32'({3'd0, 5'h01, 1'b0}));

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 5; b++) k[b] = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 149) == 0), k, ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0) ? '0 : ADDR_W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
